// File: rtl/alu_seq_responder_pkg.sv
// Shared opcode and state encodings for the multi-cycle ALU responder.
package alu_seq_responder_pkg;

   localparam int unsigned OPCODE_W = 3;

   typedef enum logic [OPCODE_W-1:0] {
      OP_PARITY   = 3'b000,
      OP_POPCOUNT = 3'b001,
      OP_ROTR     = 3'b010,
      OP_ROTL     = 3'b011
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Only the four low encodings are defined operations.
   function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
      return (op[OPCODE_W-1] == 1'b0);
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alu_seq_responder_if.sv
// Request/response valid-ready channel pair between an ALU initiator and the responder.
interface alu_seq_responder_if #(
   parameter int unsigned DATA_WIDTH = 1024
);
   import alu_seq_responder_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [OPCODE_W-1:0]   req_opcode;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;

   modport master (
      output req_valid, req_opcode, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/alu_seq_responder_popcount_chunk.sv
// Combinational population count of one reduction slice.
module alu_seq_responder_popcount_chunk #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0]             din,
   output logic [$clog2(WIDTH+1)-1:0]   cnt_c
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   // Sum of set bits in the slice.
   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_c = cnt_c + CNT_W'(din[i]);
      end
   end

endmodule

// File: rtl/alu_seq_responder.sv
// Multi-cycle ALU responder: chunked parity/popcount and staged rotate behind valid/ready channels.
module alu_seq_responder
   import alu_seq_responder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 1024,
   parameter int unsigned CHUNK_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_seq_responder_if.slave   bus,
   output logic                 busy
);
   localparam int unsigned SHW    = $clog2(DATA_WIDTH);
   localparam int unsigned NCH    = DATA_WIDTH / CHUNK_WIDTH;
   localparam int unsigned ACC_W  = $clog2(DATA_WIDTH + 1);
   localparam int unsigned CNT_W  = $clog2(CHUNK_WIDTH + 1);
   localparam int unsigned STEP_W = $clog2(max2(max2(NCH, SHW), 2));
   localparam int unsigned SEL_W  = $clog2(max2(SHW, 2));

   state_e                state, state_n;
   logic [STEP_W-1:0]     step, step_n;
   opcode_e               op, op_n;
   logic [DATA_WIDTH-1:0] work, work_n;
   logic [SHW-1:0]        amt, amt_n;
   logic [ACC_W-1:0]      acc, acc_n;
   logic                  rsp_valid, rsp_valid_n;
   logic [DATA_WIDTH-1:0] rsp_data, rsp_data_n;
   logic                  rsp_err, rsp_err_n;

   logic [CNT_W-1:0]      chunk_cnt;
   logic [DATA_WIDTH-1:0] rot_r [SHW];
   logic [DATA_WIDTH-1:0] rot_l [SHW];
   logic [SEL_W-1:0]      sel;
   logic                  is_reduce;
   logic                  last_step;

   assign bus.req_ready = rst_n && (state == ST_IDLE);
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_err   = rsp_err;

   // Working register shifts down one slice per cycle, so the LSB slice is always the next one.
   alu_seq_responder_popcount_chunk #(
      .WIDTH (CHUNK_WIDTH)
   ) u_popcount_chunk (
      .din   (work[CHUNK_WIDTH-1:0]),
      .cnt_c (chunk_cnt)
   );

   // Fixed power-of-two rotations of the working register, one per stage.
   for (genvar i = 0; i < SHW; i++) begin : g_rot
      localparam int unsigned SH = 2 ** i;
      assign rot_r[i] = {work[SH-1:0], work[DATA_WIDTH-1:SH]};
      assign rot_l[i] = {work[DATA_WIDTH-1-SH:0], work[DATA_WIDTH-1:DATA_WIDTH-SH]};
   end

   assign sel       = SEL_W'(step);
   assign is_reduce = (op == OP_PARITY) || (op == OP_POPCOUNT);
   assign last_step = is_reduce ? (step == STEP_W'(NCH - 1)) : (step == STEP_W'(SHW - 1));

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         step      <= '0;
         op        <= OP_PARITY;
         work      <= '0;
         amt       <= '0;
         acc       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         step      <= step_n;
         op        <= op_n;
         work      <= work_n;
         amt       <= amt_n;
         acc       <= acc_n;
         rsp_valid <= rsp_valid_n;
         rsp_data  <= rsp_data_n;
         rsp_err   <= rsp_err_n;
         busy      <= (state_n != ST_IDLE);
      end
   end

   // Next-state, datapath step and response generation.
   always_comb begin
      state_n     = state;
      step_n      = step;
      op_n        = op;
      work_n      = work;
      amt_n       = amt;
      acc_n       = acc;
      rsp_valid_n = rsp_valid;
      rsp_data_n  = rsp_data;
      rsp_err_n   = rsp_err;

      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (is_legal_op(bus.req_opcode)) begin
                  state_n = ST_RUN;
                  step_n  = '0;
                  op_n    = opcode_e'(bus.req_opcode);
                  work_n  = bus.req_a;
                  amt_n   = bus.req_b[SHW-1:0];
                  acc_n   = '0;
               end else begin
                  state_n     = ST_DONE;
                  rsp_valid_n = 1'b1;
                  rsp_data_n  = '0;
                  rsp_err_n   = 1'b1;
               end
            end
         end

         ST_RUN: begin
            step_n = step + STEP_W'(1);
            if (is_reduce) begin
               work_n = work >> CHUNK_WIDTH;
               acc_n  = acc + ACC_W'(chunk_cnt);
            end else begin
               // Amount register also shifts, so its LSB is this stage's enable.
               if (amt[0]) begin
                  work_n = (op == OP_ROTR) ? rot_r[sel] : rot_l[sel];
               end
               amt_n = amt >> 1;
            end
            if (last_step) begin
               state_n     = ST_DONE;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b0;
               if (op == OP_PARITY) begin
                  rsp_data_n = DATA_WIDTH'(acc_n[0]);
               end else if (op == OP_POPCOUNT) begin
                  rsp_data_n = DATA_WIDTH'(acc_n);
               end else begin
                  rsp_data_n = work_n;
               end
            end
         end

         ST_DONE: begin
            if (bus.rsp_ready) begin
               state_n     = ST_IDLE;
               rsp_valid_n = 1'b0;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Randomized self-checking bench for alu_seq_responder against a behavioural model.
module tb_alu_seq_responder;
   localparam int unsigned DW  = 1024;
   localparam int unsigned CW  = 64;
   localparam int unsigned SHW = 10;
   localparam int unsigned NCH = DW / CW;

   logic clk;
   logic rst_n;
   logic busy;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_seq_responder_if #(.DATA_WIDTH(DW)) bus ();

   alu_seq_responder #(
      .DATA_WIDTH  (DW),
      .CHUNK_WIDTH (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      logic [DW-1:0] diff;
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         diff = got ^ exp;
         $display("FAIL %s: got[127:0]=%h exp[127:0]=%h differing_bits=%0d",
                  tag, got[127:0], exp[127:0], $countones(diff));
      end
   endtask

   // Reference result from the operation definitions.
   function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [2*DW-1:0] dbl;
      int ones;
      int amount;
      ones   = 0;
      amount = int'(b[SHW-1:0]);
      for (int i = 0; i < DW; i++) ones += int'(a[i]);
      dbl = {a, a};
      case (op)
         3'd0:    return DW'(ones % 2);
         3'd1:    return DW'(ones);
         3'd2:    begin dbl = dbl >> amount; return dbl[DW-1:0];       end
         3'd3:    begin dbl = dbl << amount; return dbl[2*DW-1:DW];    end
         default: return '0;
      endcase
   endfunction

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // One full request/response transaction with optional response backpressure.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int hold, output logic [DW-1:0] got);
      logic [DW-1:0] exp;
      int lat;
      int exp_lat;
      exp     = model(op, a, b);
      exp_lat = (op > 3'd3) ? 0 : ((op < 3'd2) ? int'(NCH) : int'(SHW));
      @(negedge clk);
      check({tag, ".req_ready"}, DW'(bus.req_ready), DW'(1));
      bus.req_valid  = 1'b1;
      bus.req_opcode = op;
      bus.req_a      = a;
      bus.req_b      = b;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_a      = rand_wide();
      bus.req_b      = rand_wide();
      check({tag, ".busy"}, DW'(busy), DW'(1));
      lat = 0;
      while (!bus.rsp_valid && lat < 64) begin
         bus.rsp_ready = 1'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      bus.rsp_ready = 1'b0;
      got = bus.rsp_data;
      check({tag, ".latency"}, DW'(lat), DW'(exp_lat));
      check({tag, ".data"}, bus.rsp_data, exp);
      check({tag, ".err"}, DW'(bus.rsp_err), DW'(op > 3'd3));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({tag, ".hold_valid"}, DW'(bus.rsp_valid), DW'(1));
         check({tag, ".hold_data"}, bus.rsp_data, exp);
         check({tag, ".hold_ready"}, DW'(bus.req_ready), DW'(0));
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      check({tag, ".post_valid"}, DW'(bus.rsp_valid), DW'(0));
      check({tag, ".post_busy"}, DW'(busy), DW'(0));
      check({tag, ".post_data"}, bus.rsp_data, exp);
   endtask

   initial begin
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] got;
      logic [DW-1:0] want;
      logic [2:0]    op;
      logic          seen;

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_opcode = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.rsp_ready  = 1'b0;
      #3;
      check("reset.rsp_valid", DW'(bus.rsp_valid), DW'(0));
      check("reset.rsp_data", bus.rsp_data, '0);
      check("reset.rsp_err", DW'(bus.rsp_err), DW'(0));
      check("reset.busy", DW'(busy), DW'(0));
      check("reset.req_ready", DW'(bus.req_ready), DW'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Parity and popcount directed cases.
      run_op("parity_even", 3'd0, DW'(8'b10101100), '0, 0, got);
      run_op("parity_odd", 3'd0, DW'(8'b10101101), '0, 0, got);
      check("parity_odd.const", got, DW'(1));
      run_op("popcount_6", 3'd1, DW'(8'b11101101), '0, 0, got);
      check("popcount_6.const", got, DW'(6));
      run_op("popcount_all", 3'd1, '1, '0, 0, got);
      want = '0;
      want[10] = 1'b1;
      check("popcount_all.const", got, want);

      // Rotate directed cases, including full-width amount folding to zero.
      run_op("rotr_3", 3'd2, DW'(8'b10101101), DW'(3), 0, got);
      want = '0;
      want[4:0]     = 5'b10101;
      want[DW-1:DW-3] = 3'b101;
      check("rotr_3.const", got, want);
      a = rand_wide();
      run_op("rotr_1024", 3'd2, a, DW'(DW), 0, got);
      check("rotr_1024.identity", got, a);
      a = '0;
      a[DW-1:DW-8] = 8'b10101101;
      run_op("rotl_3", 3'd3, a, DW'(3), 0, got);
      want = '0;
      want[DW-1:DW-5] = 5'b01101;
      want[2:0]       = 3'b101;
      check("rotl_3.const", got, want);

      // Backpressure and illegal opcode.
      run_op("backpressure", 3'd1, rand_wide(), '0, 5, got);
      run_op("illegal_7", 3'd7, rand_wide(), rand_wide(), 2, got);

      // Reset abort in the middle of a popcount.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_opcode = 3'd1;
      bus.req_a      = rand_wide();
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort.rsp_valid", DW'(bus.rsp_valid), DW'(0));
      check("abort.busy", DW'(busy), DW'(0));
      check("abort.req_ready", DW'(bus.req_ready), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (NCH + 4) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid || busy) seen = 1'b1;
      end
      check("abort.no_response", DW'(seen), DW'(0));
      run_op("after_abort", 3'd0, DW'(8'b10101101), '0, 0, got);

      // Random operations against the reference model.
      for (int n = 0; n < 24; n++) begin
         op = 3'($urandom_range(0, 4));
         if (op == 3'd4) op = 3'($urandom_range(4, 7));
         a = rand_wide();
         if ($urandom_range(0, 3) == 0) a = a & rand_wide() & rand_wide();
         b = rand_wide();
         run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, int'($urandom_range(0, 3)), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
